pcl_cmd_parser: RTL and testbench

- Sits between ftdiController (byte side) and the 3-wire master (transaction side).
- Receives host bytes through the ftdiController RX 4-phase handshake and assembles them into one 3-wire read or write request.
- Issues the request, waits for completion, then returns read data or a status byte through the ftdiController TX 4-phase handshake.

---
 rtl/pcl_cmd_parser_pkg.sv | 22 ++
 rtl/pcl_cmd_parser_hsk4_rx.sv | 49 ++++
 rtl/pcl_cmd_parser.sv | 231 +++++++++++++++++++++++
 tb/tb_pcl_cmd_parser.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcl_cmd_parser_pkg.sv
// Shared constants, FSM state encoding and sizing helper for pcl_cmd_parser.
package pcl_cmd_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } pcl_state_e;

    function automatic int byte_cnt(input int bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/pcl_cmd_parser_hsk4_rx.sv
// 4-phase receive slave: latches one byte per req/ack handshake and flags it
// to the parser for exactly one cycle.
module hsk4_rx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       req,
    input  logic [7:0] data,
    output logic       ack,
    output logic       byte_vld,
    output logic [7:0] byte_data
);

    logic       ack_q, ack_d;
    logic       vld_q, vld_d;
    logic [7:0] data_q, data_d;

    always_comb begin
        ack_d  = ack_q;
        vld_d  = 1'b0;
        data_d = data_q;
        if (!ack_q) begin
            if (req && en) begin
                ack_d  = 1'b1;
                vld_d  = 1'b1;
                data_d = data;
            end
        end else if (!req) begin
            ack_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_q  <= 1'b0;
            vld_q  <= 1'b0;
            data_q <= 8'h00;
        end else begin
            ack_q  <= ack_d;
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign ack       = ack_q;
    assign byte_vld  = vld_q;
    assign byte_data = data_q;

endmodule

// File: rtl/pcl_cmd_parser.sv
// Byte-stream to 3-wire transaction bridge. Optional inter-byte timeout is
// enabled by defining PCL_CMD_RX_TIMEOUT_EN.
module pcl_cmd_parser
    import pcl_cmd_pkg::*;
#(
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 in_clk,
    input  logic                 in_rst_n,
    output logic                 out_rx_en,
    input  logic                 in_rx_hsk_req,
    output logic                 out_rx_hsk_ack,
    input  logic [7:0]           in_rx_data,
    output logic                 out_tx_hsk_req,
    input  logic                 in_tx_hsk_ack,
    output logic [7:0]           out_tx_data,
    output logic                 out_tw_start,
    output logic                 out_tw_rw,
    output logic [ADDR_BITS-1:0] out_tw_addr,
    output logic [DATA_BITS-1:0] out_tw_wdata,
    input  logic                 in_tw_busy,
    input  logic                 in_tw_done,
    input  logic [DATA_BITS-1:0] in_tw_rdata
);

    localparam int ADDR_BYTES = byte_cnt(ADDR_BITS);
    localparam int DATA_BYTES = byte_cnt(DATA_BITS);
    localparam int AW8        = ADDR_BYTES * 8;
    localparam int DW8        = DATA_BYTES * 8;
    localparam int MAX_BYTES  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam int CNT_W      = $clog2(MAX_BYTES) + 1;

    logic       rx_byte_vld;
    logic [7:0] rx_byte;

    hsk4_rx u_rx (
        .clk       (in_clk),
        .rst_n     (in_rst_n),
        .en        (out_rx_en),
        .req       (in_rx_hsk_req),
        .data      (in_rx_data),
        .ack       (out_rx_hsk_ack),
        .byte_vld  (rx_byte_vld),
        .byte_data (rx_byte)
    );

    pcl_state_e       state_q, state_d;
    logic             rw_q, rw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] left_q, left_d;
    logic [AW8-1:0]   addr_q, addr_d;
    logic [DW8-1:0]   wdata_q, wdata_d;
    logic [DW8-1:0]   resp_q, resp_d;
    logic [DW8-1:0]   rdata_ext;
    logic             tx_req_q, tx_req_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_phase_q, tx_phase_d;
    logic             start_q, start_d;
    logic             rx_en_q, rx_en_d;

    assign rdata_ext = DW8'(in_tw_rdata);

`ifdef PCL_CMD_RX_TIMEOUT_EN
    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [GAP_W-1:0] gap_q, gap_d;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        cnt_d      = cnt_q;
        left_d     = left_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        resp_d     = resp_q;
        tx_req_d   = tx_req_q;
        tx_data_d  = tx_data_q;
        tx_phase_d = tx_phase_q;
        start_d    = 1'b0;

        case (state_q)
            ST_CMD: begin
                if (rx_byte_vld) begin
                    if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) begin
                        state_d = ST_ADDR;
                        cnt_d   = '0;
                        rw_d    = (rx_byte == CMD_READ);
                    end else begin
                        state_d    = ST_RESP;
                        tx_req_d   = 1'b1;
                        tx_data_d  = RSP_NAK;
                        tx_phase_d = 1'b0;
                        left_d     = CNT_W'(1);
                    end
                end
            end
            ST_ADDR: begin
                if (rx_byte_vld) begin
                    addr_d = (addr_q << 8) | AW8'(rx_byte);
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(ADDR_BYTES - 1)) begin
                        cnt_d   = '0;
                        state_d = rw_q ? ST_ISSUE : ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (rx_byte_vld) begin
                    wdata_d = (wdata_q << 8) | DW8'(rx_byte);
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_BYTES - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // The host must have fully released the last byte before the bus goes.
                if (!in_tw_busy && !out_rx_hsk_ack) begin
                    start_d = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (in_tw_done) begin
                    state_d    = ST_RESP;
                    tx_req_d   = 1'b1;
                    tx_phase_d = 1'b0;
                    if (rw_q) begin
                        tx_data_d = rdata_ext[DW8-1 -: 8];
                        resp_d    = rdata_ext << 8;
                        left_d    = CNT_W'(DATA_BYTES);
                    end else begin
                        tx_data_d = RSP_ACK;
                        left_d    = CNT_W'(1);
                    end
                end
            end
            ST_RESP: begin
                // phase 0: req up, waiting for ack; phase 1: req down, waiting for ack release
                if (!tx_phase_q) begin
                    if (in_tx_hsk_ack) begin
                        tx_req_d   = 1'b0;
                        tx_phase_d = 1'b1;
                    end
                end else if (!in_tx_hsk_ack) begin
                    if (left_q == CNT_W'(1)) begin
                        state_d    = ST_CMD;
                        tx_phase_d = 1'b0;
                    end else begin
                        tx_req_d   = 1'b1;
                        tx_phase_d = 1'b0;
                        tx_data_d  = resp_q[DW8-1 -: 8];
                        resp_d     = resp_q << 8;
                        left_d     = left_q - 1'b1;
                    end
                end
            end
            default: state_d = ST_CMD;
        endcase

`ifdef PCL_CMD_RX_TIMEOUT_EN
        gap_d = '0;
        if ((state_q == ST_ADDR || state_q == ST_DATA) && !rx_byte_vld) begin
            if (gap_q == GAP_W'(TIMEOUT_CYCLES)) begin
                state_d    = ST_RESP;
                cnt_d      = '0;
                tx_req_d   = 1'b1;
                tx_data_d  = RSP_NAK;
                tx_phase_d = 1'b0;
                left_d     = CNT_W'(1);
            end else begin
                gap_d = gap_q + 1'b1;
            end
        end
`endif

        rx_en_d = (state_d == ST_CMD) || (state_d == ST_ADDR) || (state_d == ST_DATA);
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state_q    <= ST_CMD;
            rw_q       <= 1'b0;
            cnt_q      <= '0;
            left_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_q     <= '0;
            tx_req_q   <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_phase_q <= 1'b0;
            start_q    <= 1'b0;
            rx_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            cnt_q      <= cnt_d;
            left_q     <= left_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            resp_q     <= resp_d;
            tx_req_q   <= tx_req_d;
            tx_data_q  <= tx_data_d;
            tx_phase_q <= tx_phase_d;
            start_q    <= start_d;
            rx_en_q    <= rx_en_d;
        end
    end

`ifdef PCL_CMD_RX_TIMEOUT_EN
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) gap_q <= '0;
        else           gap_q <= gap_d;
    end
`endif

    assign out_rx_en      = rx_en_q;
    assign out_tx_hsk_req = tx_req_q;
    assign out_tx_data    = tx_data_q;
    assign out_tw_start   = start_q;
    assign out_tw_rw      = rw_q;
    assign out_tw_addr    = addr_q[ADDR_BITS-1:0];
    assign out_tw_wdata   = wdata_q[DATA_BITS-1:0];

endmodule

// File: tb/tb_pcl_cmd_parser.sv
// Directed scoreboard bench for pcl_cmd_parser with 3-wire master and TX host models.
module tb_pcl_cmd_parser;

    logic        in_clk = 1'b0;
    logic        in_rst_n = 1'b0;
    logic        out_rx_en;
    logic        in_rx_hsk_req = 1'b0;
    logic        out_rx_hsk_ack;
    logic [7:0]  in_rx_data = 8'h00;
    logic        out_tx_hsk_req;
    logic        in_tx_hsk_ack = 1'b0;
    logic [7:0]  out_tx_data;
    logic        out_tw_start;
    logic        out_tw_rw;
    logic [7:0]  out_tw_addr;
    logic [15:0] out_tw_wdata;
    logic        in_tw_busy = 1'b0;
    logic        in_tw_done;
    logic [15:0] in_tw_rdata = 16'h0000;

    logic done_model = 1'b0;
    logic stray_done = 1'b0;
    assign in_tw_done = done_model | stray_done;

    pcl_cmd_parser dut (
        .in_clk         (in_clk),
        .in_rst_n       (in_rst_n),
        .out_rx_en      (out_rx_en),
        .in_rx_hsk_req  (in_rx_hsk_req),
        .out_rx_hsk_ack (out_rx_hsk_ack),
        .in_rx_data     (in_rx_data),
        .out_tx_hsk_req (out_tx_hsk_req),
        .in_tx_hsk_ack  (in_tx_hsk_ack),
        .out_tx_data    (out_tx_data),
        .out_tw_start   (out_tw_start),
        .out_tw_rw      (out_tw_rw),
        .out_tw_addr    (out_tw_addr),
        .out_tw_wdata   (out_tw_wdata),
        .in_tw_busy     (in_tw_busy),
        .in_tw_done     (in_tw_done),
        .in_tw_rdata    (in_tw_rdata)
    );

    always #5 in_clk = ~in_clk;

    typedef struct packed {
        logic        rw;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } tw_t;

    tw_t        exp_tw_q[$];
    logic [7:0] exp_tx_q[$];
    tw_t        cur_tw;
    int         n_tests = 0;
    int         n_fail = 0;
    int         start_cnt = 0;
    int         start_exp = 0;
    int         tx_cnt = 0;
    int         tx_exp = 0;
    int         done_cnt = 0;
    logic       chk_txreq = 1'b0;
    logic       tx_stall = 1'b0;
    logic [15:0] rdata_val = 16'h0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 3-wire master: done 4 cycles after start, checks request and its stability.
    always @(negedge in_clk) begin
        done_model = 1'b0;
        if (!in_rst_n) begin
            done_cnt  = 0;
            chk_txreq = 1'b0;
        end else begin
            if (chk_txreq) begin
                check("done_to_tx_req", out_tx_hsk_req, 1'b1);
                chk_txreq = 1'b0;
            end
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) begin
                    check("tw_rw_stable", out_tw_rw, cur_tw.rw);
                    check("tw_addr_stable", out_tw_addr, cur_tw.addr);
                    if (!cur_tw.rw) check("tw_wdata_stable", out_tw_wdata, cur_tw.wdata);
                    in_tw_rdata = rdata_val;
                    done_model  = 1'b1;
                    chk_txreq   = 1'b1;
                end
            end
            if (out_tw_start) begin
                start_cnt++;
                check("tw_start_expected", exp_tw_q.size() != 0, 1'b1);
                if (exp_tw_q.size() != 0) begin
                    cur_tw = exp_tw_q.pop_front();
                    check("tw_rw", out_tw_rw, cur_tw.rw);
                    check("tw_addr", out_tw_addr, cur_tw.addr);
                    if (!cur_tw.rw) check("tw_wdata", out_tw_wdata, cur_tw.wdata);
                end
                done_cnt = 4;
            end
        end
    end

    // TX host: acks each req after checking its byte, releases ack after req drops.
    always @(negedge in_clk) begin
        if (out_tx_hsk_req && !in_tx_hsk_ack && !tx_stall) begin
            tx_cnt++;
            check("tx_byte_expected", exp_tx_q.size() != 0, 1'b1);
            if (exp_tx_q.size() != 0) check("tx_data", out_tx_data, exp_tx_q.pop_front());
            in_tx_hsk_ack = 1'b1;
        end else if (!out_tx_hsk_req && in_tx_hsk_ack) begin
            in_tx_hsk_ack = 1'b0;
        end
    end

    task automatic rx_begin(input logic [7:0] b);
        in_rx_data    = b;
        in_rx_hsk_req = 1'b1;
    endtask

    task automatic rx_finish();
        for (int i = 0; i < 500 && !out_rx_hsk_ack; i++) @(negedge in_clk);
        check("rx_ack_seen", out_rx_hsk_ack, 1'b1);
        in_rx_hsk_req = 1'b0;
        for (int i = 0; i < 50 && out_rx_hsk_ack; i++) @(negedge in_clk);
        check("rx_ack_released", out_rx_hsk_ack, 1'b0);
    endtask

    task automatic rx_send(input logic [7:0] b);
        rx_begin(b);
        @(negedge in_clk);
        rx_finish();
    endtask

    task automatic expect_tw(input logic rw, input logic [7:0] a, input logic [15:0] d);
        tw_t t;
        t.rw = rw; t.addr = a; t.wdata = d;
        exp_tw_q.push_back(t);
        start_exp++;
    endtask

    task automatic expect_tx(input logic [7:0] b);
        exp_tx_q.push_back(b);
        tx_exp++;
    endtask

    task automatic wait_idle(input string tag);
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 2000 && !idle; i++) begin
            @(negedge in_clk);
            idle = (exp_tx_q.size() == 0) && (exp_tw_q.size() == 0) && !out_tx_hsk_req
                   && !in_tx_hsk_ack && (done_cnt == 0) && out_rx_en;
        end
        check(tag, idle, 1'b1);
    endtask

    int s0;

    initial begin
        // reset state
        repeat (3) @(negedge in_clk);
        check("rst_rx_en", out_rx_en, 1'b0);
        check("rst_rx_ack", out_rx_hsk_ack, 1'b0);
        check("rst_tx_req", out_tx_hsk_req, 1'b0);
        check("rst_tw_start", out_tw_start, 1'b0);
        check("rst_tw_bus", {out_tw_rw, out_tw_addr, out_tw_wdata, out_tx_data}, 32'h0);
        in_rst_n = 1'b1;
        @(negedge in_clk);
        check("rx_en_after_rst", out_rx_en, 1'b1);

        // write frame
        rdata_val = 16'h0000;
        expect_tw(1'b0, 8'h12, 16'hABCD);
        expect_tx(8'h06);
        rx_send(8'h57); rx_send(8'h12); rx_send(8'hAB); rx_send(8'hCD);
        wait_idle("write_idle");

        // read frame
        rdata_val = 16'hBEEF;
        expect_tw(1'b1, 8'h34, 16'h0000);
        expect_tx(8'hBE); expect_tx(8'hEF);
        rx_send(8'h52); rx_send(8'h34);
        wait_idle("read_idle");

        // bad command then a normal read
        expect_tx(8'h15);
        rx_send(8'h99);
        wait_idle("nak_idle");
        rdata_val = 16'h1234;
        expect_tw(1'b1, 8'hA5, 16'h0000);
        expect_tx(8'h12); expect_tx(8'h34);
        rx_send(8'h52); rx_send(8'hA5);
        wait_idle("after_nak_idle");
        check("start_count_nak", start_cnt, start_exp);

        // done pulse outside WAIT is ignored
        @(negedge in_clk); stray_done = 1'b1;
        @(negedge in_clk); stray_done = 1'b0;
        repeat (5) @(negedge in_clk);
        check("stray_done_no_tx", out_tx_hsk_req, 1'b0);

        // backpressure at ISSUE, with a held host byte
        in_tw_busy = 1'b1;
        s0 = start_cnt;
        expect_tw(1'b0, 8'h5A, 16'h0F0F);
        expect_tx(8'h06);
        expect_tx(8'h15);
        rx_send(8'h57); rx_send(8'h5A); rx_send(8'h0F); rx_send(8'h0F);
        rx_begin(8'h99);
        repeat (50) @(negedge in_clk);
        check("bp_rx_en_low", out_rx_en, 1'b0);
        check("bp_no_ack", out_rx_hsk_ack, 1'b0);
        check("bp_no_start", start_cnt, s0);
        in_tw_busy = 1'b0;
        @(negedge in_clk);
        check("bp_start_after_busy", out_tw_start, 1'b1);
        rx_finish();
        wait_idle("bp_idle");

        // reset in the middle of a read response
        rdata_val = 16'hBEEF;
        expect_tw(1'b1, 8'h56, 16'h0000);
        expect_tx(8'hBE); expect_tx(8'hEF);
        rx_send(8'h52); rx_send(8'h56);
        s0 = tx_cnt;
        for (int i = 0; i < 500 && tx_cnt == s0; i++) @(negedge in_clk);
        tx_stall = 1'b1;
        check("mid_resp_first_byte", tx_cnt, s0 + 1);
        for (int i = 0; i < 50 && !(out_tx_hsk_req && !in_tx_hsk_ack); i++) @(negedge in_clk);
        check("mid_resp_second_req", out_tx_hsk_req, 1'b1);
        in_rst_n = 1'b0;
        @(negedge in_clk);
        check("rst_mid_tx_req", out_tx_hsk_req, 1'b0);
        check("rst_mid_start", out_tw_start, 1'b0);
        tx_exp = tx_exp - exp_tx_q.size();
        exp_tx_q.delete();
        tx_stall = 1'b0;
        @(negedge in_clk);
        in_rst_n = 1'b1;
        @(negedge in_clk);
        check("rx_en_after_rst2", out_rx_en, 1'b1);
        expect_tw(1'b0, 8'h00, 16'h0001);
        expect_tx(8'h06);
        rx_send(8'h57); rx_send(8'h00); rx_send(8'h00); rx_send(8'h01);
        wait_idle("post_rst_idle");

        check("total_starts", start_cnt, start_exp);
        check("total_tx", tx_cnt, tx_exp);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
